// File: rtl/mips_datapath_pc_register.sv
// Program-counter register and next-PC unit: holds the fetch PC, applies EX
// redirects (branch/jump/register), drives the fetch handshake and traps on misaligned targets.
module mips_datapath_pc_register #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter int          COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   redirect_valid,
  input  logic [1:0]             action,
  input  logic [31:0]            link_pc,
  input  logic [15:0]            branch_offset,
  input  logic [25:0]            jump_index,
  input  logic [31:0]            register_target,
  input  logic                   stall,
  input  logic                   fetch_ready,
  output logic                   fetch_valid,
  output logic [31:0]            fetch_addr,
  output logic                   flush,
  output logic                   fault,
  output logic [31:0]            fault_addr,
  output logic [COUNT_WIDTH-1:0] redirect_count
);

  localparam logic [1:0] ACT_INC      = 2'd0;
  localparam logic [1:0] ACT_BRANCH   = 2'd1;
  localparam logic [1:0] ACT_JUMP     = 2'd2;
  localparam logic [1:0] ACT_REGISTER = 2'd3;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    if (&c) sat_inc = c;
    else    sat_inc = c + 1'b1;
  endfunction

  state_t                 state_p0, state_nxt;
  logic [31:0]            pc_p0, pc_nxt;
  logic                   flush_p0, flush_nxt;
  logic                   fault_p0, fault_nxt;
  logic [31:0]            fault_addr_p0, fault_addr_nxt;
  logic [COUNT_WIDTH-1:0] count_p0, count_nxt;

  logic signed [31:0] branch_disp;
  logic [31:0]        target;
  logic               taken;
  logic               accept;

  // Target selection; branch displacement is the sign-extended word offset.
  always_comb begin
    branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    target      = register_target;
    unique case (action)
      ACT_BRANCH:   target = link_pc + $unsigned(branch_disp);
      ACT_JUMP:     target = {link_pc[31:28], jump_index, 2'b00};
      ACT_REGISTER: target = register_target;
      default:      target = link_pc;
    endcase
  end

  assign fetch_valid = (state_p0 == RUN) && !stall;
  assign accept      = fetch_valid && fetch_ready;
  assign taken       = (state_p0 == RUN) && redirect_valid && (action != ACT_INC);

  // Next-state: a taken redirect outranks stall and fetch acceptance.
  always_comb begin
    state_nxt      = state_p0;
    pc_nxt         = pc_p0;
    flush_nxt      = 1'b0;
    fault_nxt      = fault_p0;
    fault_addr_nxt = fault_addr_p0;
    count_nxt      = count_p0;
    unique case (state_p0)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (taken) begin
          flush_nxt = 1'b1;
          if (target[1:0] != 2'b00) begin
            state_nxt      = FAULT;
            fault_nxt      = 1'b1;
            fault_addr_nxt = target;
          end else begin
            pc_nxt    = target;
            count_nxt = sat_inc(count_p0);
          end
        end else if (accept) begin
          pc_nxt = pc_p0 + 32'd4;
        end
      end
      default: state_nxt = FAULT;
    endcase
  end

  // Single register stage holding all architectural PC state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_p0      <= BOOT;
      pc_p0         <= RESET_VECTOR;
      flush_p0      <= 1'b0;
      fault_p0      <= 1'b0;
      fault_addr_p0 <= 32'd0;
      count_p0      <= '0;
    end else begin
      state_p0      <= state_nxt;
      pc_p0         <= pc_nxt;
      flush_p0      <= flush_nxt;
      fault_p0      <= fault_nxt;
      fault_addr_p0 <= fault_addr_nxt;
      count_p0      <= count_nxt;
    end
  end

  assign fetch_addr     = pc_p0;
  assign flush          = flush_p0;
  assign fault          = fault_p0;
  assign fault_addr     = fault_addr_p0;
  assign redirect_count = count_p0;

endmodule

// File: tb/tb_mips_datapath_pc_register.sv
// Directed bench for the PC register: boot, stall, redirects, wrap, counter saturation,
// misaligned-target trap and asynchronous reset.
module tb_mips_datapath_pc_register;

  localparam logic [1:0] ACT_INC      = 2'd0;
  localparam logic [1:0] ACT_BRANCH   = 2'd1;
  localparam logic [1:0] ACT_JUMP     = 2'd2;
  localparam logic [1:0] ACT_REGISTER = 2'd3;

  logic        clock;
  logic        reset_n;
  logic        redirect_valid;
  logic [1:0]  action;
  logic [31:0] link_pc;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] register_target;
  logic        stall;
  logic        fetch_ready;

  logic        fetch_valid, flush, fault;
  logic [31:0] fetch_addr, fault_addr;
  logic [15:0] redirect_count;

  logic        fetch_valid2, flush2, fault2;
  logic [31:0] fetch_addr2, fault_addr2;
  logic [1:0]  redirect_count2;

  int n_err;
  int n_checks;

  mips_datapath_pc_register dut (
    .clock(clock), .reset_n(reset_n), .redirect_valid(redirect_valid), .action(action),
    .link_pc(link_pc), .branch_offset(branch_offset), .jump_index(jump_index),
    .register_target(register_target), .stall(stall), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .flush(flush), .fault(fault),
    .fault_addr(fault_addr), .redirect_count(redirect_count)
  );

  mips_datapath_pc_register #(.COUNT_WIDTH(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .redirect_valid(redirect_valid), .action(action),
    .link_pc(link_pc), .branch_offset(branch_offset), .jump_index(jump_index),
    .register_target(register_target), .stall(stall), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid2), .fetch_addr(fetch_addr2), .flush(flush2), .fault(fault2),
    .fault_addr(fault_addr2), .redirect_count(redirect_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic redirect(input logic [1:0] act, input logic [31:0] lpc,
                          input logic [15:0] off, input logic [25:0] idx,
                          input logic [31:0] rt);
    redirect_valid  = 1'b1;
    action          = act;
    link_pc         = lpc;
    branch_offset   = off;
    jump_index      = idx;
    register_target = rt;
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    action = ACT_INC;
    link_pc = '0;
    branch_offset = '0;
    jump_index = '0;
    register_target = '0;
    stall = 1'b0;
    fetch_ready = 1'b1;

    cyc(); cyc(); #1;
    chk("rst_fv", fetch_valid, 0);
    chk("rst_addr", fetch_addr, 32'h0040_0000);
    chk("rst_flush", flush, 0);
    chk("rst_fault", fault, 0);
    chk("rst_faddr", fault_addr, 0);
    chk("rst_cnt", redirect_count, 0);

    // Release reset; BOOT holds fetch_valid low until the first edge.
    reset_n = 1'b1; #1;
    chk("boot_fv", fetch_valid, 0);
    cyc(); #1;
    chk("run_fv", fetch_valid, 1);
    chk("pc0", fetch_addr, 32'h0040_0000);
    cyc(); chk("pc1", fetch_addr, 32'h0040_0004);
    cyc(); chk("pc2", fetch_addr, 32'h0040_0008);

    stall = 1'b1; #1;
    chk("stall_fv", fetch_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", fetch_addr, 32'h0040_0008);
    end
    stall = 1'b0; #1;
    chk("unstall_fv", fetch_valid, 1);
    chk("unstall_addr", fetch_addr, 32'h0040_0008);
    cyc(); chk("pc3", fetch_addr, 32'h0040_000C);

    // Backward branch: 0x00400010 + (-4 << 2) = 0x00400000.
    redirect(ACT_BRANCH, 32'h0040_0010, 16'hFFFC, 26'h0, 32'h0);
    cyc();
    chk("br_addr", fetch_addr, 32'h0040_0000);
    chk("br_flush", flush, 1);
    chk("br_cnt", redirect_count, 1);
    redirect_valid = 1'b0;
    cyc();
    chk("br_flush_end", flush, 0);
    chk("br_next", fetch_addr, 32'h0040_0004);
    redirect(ACT_INC, 32'h0040_0010, 16'hFFFC, 26'h0, 32'h0);
    cyc();
    chk("inc_addr", fetch_addr, 32'h0040_0008);
    chk("inc_flush", flush, 0);
    chk("inc_cnt", redirect_count, 1);

    // Jump coinciding with an accepted fetch: redirect wins, no +4.
    redirect(ACT_JUMP, 32'h8000_0004, 16'h0, 26'h000_0100, 32'h0);
    #1 chk("jmp_accept_fv", fetch_valid, 1);
    cyc();
    chk("jmp_addr", fetch_addr, 32'h8000_0400);
    chk("jmp_flush", flush, 1);
    chk("jmp_cnt", redirect_count, 2);
    // Back-to-back branch under stall: 0x80000400 + 16 = 0x80000410.
    redirect(ACT_BRANCH, 32'h8000_0400, 16'h0004, 26'h0, 32'h0);
    stall = 1'b1;
    cyc();
    chk("b2b_addr", fetch_addr, 32'h8000_0410);
    chk("b2b_flush", flush, 1);
    chk("b2b_cnt", redirect_count, 3);
    chk("sat_cnt3", redirect_count2, 3);
    redirect_valid = 1'b0;
    cyc();
    chk("b2b_flush_end", flush, 0);
    chk("b2b_hold", fetch_addr, 32'h8000_0410);

    // Jump to the top word, then one accept wraps to zero.
    stall = 1'b0;
    redirect(ACT_JUMP, 32'hF000_0000, 16'h0, 26'h3FF_FFFF, 32'h0);
    cyc();
    chk("top_addr", fetch_addr, 32'hFFFF_FFFC);
    chk("top_cnt", redirect_count, 4);
    redirect_valid = 1'b0;
    cyc();
    chk("wrap_addr", fetch_addr, 32'h0000_0000);
    chk("wrap_flush", flush, 0);

    redirect(ACT_REGISTER, 32'h0, 16'h0, 26'h0, 32'h0000_0100);
    cyc();
    chk("reg_addr", fetch_addr, 32'h0000_0100);
    chk("cnt5", redirect_count, 5);
    chk("sat_cnt5", redirect_count2, 3);

    // Misaligned register target traps; pc and counter stay put.
    redirect(ACT_REGISTER, 32'h0, 16'h0, 26'h0, 32'h0040_0022);
    cyc(); #1;
    chk("flt_fault", fault, 1);
    chk("flt_faddr", fault_addr, 32'h0040_0022);
    chk("flt_flush", flush, 1);
    chk("flt_fv", fetch_valid, 0);
    chk("flt_addr", fetch_addr, 32'h0000_0100);
    chk("flt_cnt", redirect_count, 5);
    redirect(ACT_JUMP, 32'h0, 16'h0, 26'h000_0001, 32'h0);
    cyc(); #1;
    chk("flt_ign_addr", fetch_addr, 32'h0000_0100);
    chk("flt_ign_cnt", redirect_count, 5);
    chk("flt_ign_flush", flush, 0);
    chk("flt_sticky", fault, 1);
    chk("flt_ign_fv", fetch_valid, 0);

    // Asynchronous reset in the middle of a cycle.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_fault", fault, 0);
    chk("arst_faddr", fault_addr, 0);
    chk("arst_cnt", redirect_count, 0);
    chk("arst_addr", fetch_addr, 32'h0040_0000);
    chk("arst_fv", fetch_valid, 0);
    chk("arst_flush", flush, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
